operand_bank: RTL and testbench

- Parametrised successor to the two-operand register updater.
- Captures switch input into one of NUM_REGS operand registers of WIDTH bits.
- Captures happen on rising edges of a load request, so one capture per button press. A clear command empties the bank.
- Tracks which operands are loaded and signals the downstream ALU when a complete operand set is available. Sits between the synchronised/debounced button+switch front end and the ALU.

---
 rtl/operand_bank_pkg.sv | 23 ++
 rtl/operand_bank_edge.sv | 29 ++
 rtl/operand_bank.sv | 149 ++++++++++++++
 tb/tb_operand_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_bank_pkg                                              |
// | Purpose  : Shared definitions for the operand bank: FSM state encoding,  |
// |            default geometry and a select-width helper for parents.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package operand_bank_pkg;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NUM_REGS = 2;

  // Width of an index able to address n registers (never below one bit).
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bank_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rise_edge_det                                                 |
// | Purpose  : One-cycle rising-edge detector on a synchronous level input.  |
// | Ports    : clk, rst (sync, active-high), in_i (level), edge_o (pulse)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rise_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic edge_o
);

  logic in_q;

  // History resets to RST_VAL; with 1 a level held across reset release
  // must drop and rise again before it is seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) in_q <= RST_VAL;
    else     in_q <= in_i;
  end

  assign edge_o = in_i & ~in_q;

endmodule
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_bank                                                  |
// | Purpose  : Bank of NUM_REGS operand registers loaded from switches on    |
// |            load-request rising edges; tracks the loaded mask and flags   |
// |            a complete operand set to the downstream ALU.                 |
// | Ports    : clk, rst         - clock, sync active-high reset             |
// |            sw_input_i       - value to capture                          |
// |            load_req_i/sel_i - load request level and target index       |
// |            clr_req_i        - clear request level                       |
// |            operands_o       - flattened registers, reg i at [i*W +: W]  |
// |            loaded_o         - per-register loaded mask                  |
// |            all_loaded_o     - bank complete                             |
// |            upd_pulse_o      - complete set (re)delivered, one cycle     |
// |            sel_err_o        - sticky out-of-range select                |
// |            load_count_o     - saturating accepted-load count            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module operand_bank
  import operand_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = sel_width(NUM_REGS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          sw_input_i,
  input  logic                      load_req_i,
  input  logic [SEL_W-1:0]          load_sel_i,
  input  logic                      clr_req_i,
  output logic [NUM_REGS*WIDTH-1:0] operands_o,
  output logic [NUM_REGS-1:0]       loaded_o,
  output logic                      all_loaded_o,
  output logic                      upd_pulse_o,
  output logic                      sel_err_o,
  output logic [CNT_W-1:0]          load_count_o
);

  localparam logic [SEL_W:0] c_NUM_REGS_X = (SEL_W+1)'(NUM_REGS);

  logic                w_load_edge;
  logic                w_clr_edge;
  logic                w_sel_ok;
  logic                w_accept;
  logic                w_reject;
  logic [NUM_REGS-1:0] w_sel_hot;

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] loaded_q, loaded_d;
  logic [1:0]          state_q, state_d;
  logic                upd_pulse_q, upd_pulse_d;
  logic                sel_err_q, sel_err_d;
  logic [CNT_W-1:0]    count_q, count_d;

  rise_edge_det #(.RST_VAL(1'b1)) u_load_edge (
    .clk    (clk),
    .rst    (rst),
    .in_i   (load_req_i),
    .edge_o (w_load_edge)
  );

  rise_edge_det #(.RST_VAL(1'b1)) u_clr_edge (
    .clk    (clk),
    .rst    (rst),
    .in_i   (clr_req_i),
    .edge_o (w_clr_edge)
  );

  // Extra leading bit so the range check also works when NUM_REGS is a
  // power of two (index can never be out of range then).
  assign w_sel_ok = ({1'b0, load_sel_i} < c_NUM_REGS_X);
  // Clear dominates a coincident load.
  assign w_accept = w_load_edge & ~w_clr_edge &  w_sel_ok;
  assign w_reject = w_load_edge & ~w_clr_edge & ~w_sel_ok;

  always_comb begin
    w_sel_hot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (load_sel_i == SEL_W'(i)) w_sel_hot[i] = 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_clr_edge)                   regs_d[i] = '0;
      else if (w_accept && w_sel_hot[i]) regs_d[i] = sw_input_i;
    end
  end

  always_comb begin
    loaded_d = loaded_q;
    if (w_clr_edge)    loaded_d = '0;
    else if (w_accept) loaded_d = loaded_q | w_sel_hot;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY, ST_PARTIAL: begin
        if (w_clr_edge)    state_d = ST_EMPTY;
        else if (w_accept) state_d = (&loaded_d) ? ST_FULL : ST_PARTIAL;
      end
      ST_FULL: begin
        if (w_clr_edge) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Registered alongside the operand write, so the pulse lines up with the
  // completing/refreshing value on operands_o.
  assign upd_pulse_d = w_accept & (&loaded_d);
  assign sel_err_d   = sel_err_q | w_reject;
  assign count_d     = (w_accept && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      loaded_q    <= '0;
      state_q     <= ST_EMPTY;
      upd_pulse_q <= 1'b0;
      sel_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      loaded_q    <= loaded_d;
      state_q     <= state_d;
      upd_pulse_q <= upd_pulse_d;
      sel_err_q   <= sel_err_d;
      count_q     <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign operands_o[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign loaded_o     = loaded_q;
  assign all_loaded_o = (state_q == ST_FULL);
  assign upd_pulse_o  = upd_pulse_q;
  assign sel_err_o    = sel_err_q;
  assign load_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_operand_bank                                               |
// | Purpose  : Directed self-checking bench for operand_bank with default    |
// |            geometry (8/2) and a non-power-of-two bank (4/3).             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_operand_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance (WIDTH 8, NUM_REGS 2)
  logic [7:0]  sw_d    = '0;
  logic        lreq_d  = 1'b0;
  logic [0:0]  lsel_d  = '0;
  logic        creq_d  = 1'b0;
  logic [15:0] ops_d;
  logic [1:0]  ld_d;
  logic        all_d, upd_d, err_d;
  logic [7:0]  cnt_d;

  // Non-power-of-two instance (WIDTH 4, NUM_REGS 3)
  logic [3:0]  sw_3    = '0;
  logic        lreq_3  = 1'b0;
  logic [1:0]  lsel_3  = '0;
  logic        creq_3  = 1'b0;
  logic [11:0] ops_3;
  logic [2:0]  ld_3;
  logic        all_3, upd_3, err_3;
  logic [7:0]  cnt_3;

  operand_bank u_dut_d (
    .clk(clk), .rst(rst), .sw_input_i(sw_d), .load_req_i(lreq_d),
    .load_sel_i(lsel_d), .clr_req_i(creq_d), .operands_o(ops_d),
    .loaded_o(ld_d), .all_loaded_o(all_d), .upd_pulse_o(upd_d),
    .sel_err_o(err_d), .load_count_o(cnt_d)
  );

  operand_bank #(.WIDTH(4), .NUM_REGS(3)) u_dut_3 (
    .clk(clk), .rst(rst), .sw_input_i(sw_3), .load_req_i(lreq_3),
    .load_sel_i(lsel_3), .clr_req_i(creq_3), .operands_o(ops_3),
    .loaded_o(ld_3), .all_loaded_o(all_3), .upd_pulse_o(upd_3),
    .sel_err_o(err_3), .load_count_o(cnt_3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int base;

  // Counts clock cycles in which the default instance's pulse is high.
  always @(negedge clk) if (upd_d === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_d(input logic [0:0] sel, input logic [7:0] val);
    lsel_d = sel; sw_d = val; lreq_d = 1'b1;
    tick();
  endtask

  task automatic rel_d();
    lreq_d = 1'b0;
    tick();
  endtask

  task automatic load_3(input logic [1:0] sel, input logic [3:0] val);
    lsel_3 = sel; sw_3 = val; lreq_3 = 1'b1;
    tick();
  endtask

  task automatic rel_3();
    lreq_3 = 1'b0;
    tick();
  endtask

  initial begin
    // Reset, then one idle cycle so edge history sees the low level.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ops",  ops_d, 0);
    chk("rst_ld",   ld_d,  0);
    chk("rst_all",  all_d, 0);
    chk("rst_upd",  upd_d, 0);
    chk("rst_err",  err_d, 0);
    chk("rst_cnt",  cnt_d, 0);

    // 1: first operand
    base = upd_cnt;
    load_d(1'b0, 8'h03);
    chk("t1_op0", ops_d[7:0], 8'h03);
    chk("t1_ld",  ld_d, 2'b01);
    chk("t1_all", all_d, 0);
    chk("t1_cnt", cnt_d, 1);
    rel_d();
    chk("t1_noupd", upd_cnt - base, 0);

    // 2: second operand completes the set
    base = upd_cnt;
    load_d(1'b1, 8'h0C);
    chk("t2_op1", ops_d[15:8], 8'h0C);
    chk("t2_upd", upd_d, 1);
    chk("t2_ld",  ld_d, 2'b11);
    chk("t2_all", all_d, 1);
    chk("t2_cnt", cnt_d, 2);
    rel_d();
    chk("t2_upd1", upd_cnt - base, 1);

    // 3: level held 20 cycles with changing data -> one load
    base = upd_cnt;
    lsel_d = 1'b0; lreq_d = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sw_d = 8'h50 + 8'(i);
      tick();
    end
    chk("t3_op0",  ops_d[7:0], 8'h50);
    chk("t3_cnt",  cnt_d, 3);
    chk("t3_ld",   ld_d, 2'b11);
    chk("t3_upd1", upd_cnt - base, 1);
    rel_d();

    // 4: clear and load on the same edge while FULL
    base = upd_cnt;
    sw_d = 8'hFF; lsel_d = 1'b1; lreq_d = 1'b1; creq_d = 1'b1;
    tick();
    chk("t4_ops", ops_d, 0);
    chk("t4_ld",  ld_d, 0);
    chk("t4_all", all_d, 0);
    chk("t4_cnt", cnt_d, 3);
    lreq_d = 1'b0; creq_d = 1'b0;
    tick();
    chk("t4_noupd", upd_cnt - base, 0);

    // 5: out-of-range select on the 3-register bank
    load_3(2'd3, 4'hA);
    chk("t5_err",  err_3, 1);
    chk("t5_ops",  ops_3, 0);
    chk("t5_ld",   ld_3, 0);
    chk("t5_cnt",  cnt_3, 0);
    rel_3();
    load_3(2'd0, 4'h5); rel_3();
    load_3(2'd1, 4'h6); rel_3();
    load_3(2'd2, 4'h7);
    chk("t5_ops3", ops_3, 12'h765);
    chk("t5_upd",  upd_3, 1);
    chk("t5_all",  all_3, 1);
    chk("t5_ld3",  ld_3, 3'b111);
    chk("t5_cnt3", cnt_3, 3);
    chk("t5_sticky", err_3, 1);
    rel_3();

    // 6: reset mid-sequence with load_req held high
    load_d(1'b0, 8'h11);
    chk("t6_pre_ld",  ld_d, 2'b01);
    chk("t6_pre_cnt", cnt_d, 4);
    rst = 1'b1;
    tick();
    chk("t6_ops",  ops_d, 0);
    chk("t6_ld",   ld_d, 0);
    chk("t6_all",  all_d, 0);
    chk("t6_upd",  upd_d, 0);
    chk("t6_cnt",  cnt_d, 0);
    chk("t6_err3", err_3, 0);
    tick();
    rst = 1'b0; sw_d = 8'h22;
    tick(); tick(); tick();
    chk("t6_hold_ld",  ld_d, 0);
    chk("t6_hold_cnt", cnt_d, 0);
    chk("t6_hold_ops", ops_d, 0);
    rel_d();
    load_d(1'b0, 8'h33);
    chk("t6_op0", ops_d[7:0], 8'h33);
    chk("t6_cnt1", cnt_d, 1);
    rel_d();

    // Saturation of the accepted-load counter
    for (int i = 0; i < 260; i++) begin
      load_d(1'b1, 8'(i));
      rel_d();
    end
    chk("sat_cnt", cnt_d, 8'd255);
    chk("sat_ld",  ld_d, 2'b11);
    chk("sat_op1", ops_d[15:8], 8'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
